// File: rtl/sub_bytes_seq.sv
// Byte-serial SubBytes over a 128-bit state using one external combined S-box.
// One byte per BUSY cycle; the result register is updated only when a block completes.
module sub_bytes_seq (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         encrypt,
    input  logic [127:0] block_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] block_out,
    output logic         sbox_encrypt,
    output logic [7:0]   sbox_byte_in,
    input  logic [7:0]   sbox_byte_out
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state_reg, state_next;
    logic [3:0]   index_reg, index_next;
    logic         mode_reg, mode_next;
    logic [127:0] work_reg, work_next;
    logic [127:0] result_reg, result_next;

    logic [7:0]   work_bytes [16];
    logic [127:0] work_subst;

    // Substituted bytes are written back in place, so the working register
    // becomes the finished result once the last lane has been processed.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_lane
            assign work_bytes[gi] = work_reg[127-8*gi -: 8];
            assign work_subst[127-8*gi -: 8] =
                (index_reg == 4'(gi)) ? sbox_byte_out : work_reg[127-8*gi -: 8];
        end
    endgenerate

    assign sbox_encrypt = mode_reg;
    assign block_out    = result_reg;

    always_comb begin
        state_next   = state_reg;
        index_next   = index_reg;
        mode_next    = mode_reg;
        work_next    = work_reg;
        result_next  = result_reg;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        sbox_byte_in = 8'h00;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    work_next  = block_in;
                    mode_next  = encrypt;
                    index_next = 4'd0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                sbox_byte_in = work_bytes[index_reg];
                work_next    = work_subst;
                index_next   = index_reg + 4'd1;   // wraps to 0 after byte 15
                if (index_reg == 4'd15) begin
                    result_next = work_subst;
                    state_next  = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            index_reg  <= 4'd0;
            mode_reg   <= 1'b1;
            work_reg   <= '0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            index_reg  <= index_next;
            mode_reg   <= mode_next;
            work_reg   <= work_next;
            result_reg <= result_next;
        end
    end
endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: GF(2^8)-derived combined S-box on the sbox ports,
// vector table plus hand-written stall, reset and back-to-back sequences.
module tb_sub_bytes_seq;
    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, encrypt, out_valid, out_ready, sbox_encrypt;
    logic [127:0] block_in, block_out;
    logic [7:0]   sbox_byte_in, sbox_byte_out;
    logic [7:0]   fwd_tab [256];
    logic [7:0]   inv_tab [256];

    always #5 clk = ~clk;

    sub_bytes_seq dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .encrypt(encrypt), .block_in(block_in), .out_valid(out_valid),
        .out_ready(out_ready), .block_out(block_out), .sbox_encrypt(sbox_encrypt),
        .sbox_byte_in(sbox_byte_in), .sbox_byte_out(sbox_byte_out)
    );

    assign sbox_byte_out = sbox_encrypt ? fwd_tab[sbox_byte_in] : inv_tab[sbox_byte_in];

    typedef struct {
        logic         enc;
        logic [127:0] blk;
        logic [127:0] exp;
        int           stall;
    } vec_t;

    vec_t         vecs [4];
    vec_t         bb [2];
    logic [127:0] exp_q [$];
    int           n_cmp = 0;
    int           n_bad = 0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    task automatic build_tables();
        logic [7:0] invx;
        for (int a = 0; a < 256; a++) begin
            invx = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) invx = 8'(b);
            fwd_tab[a] = affine(invx);
        end
        for (int a = 0; a < 256; a++) inv_tab[fwd_tab[a]] = 8'(a);
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic pop_check(input string name);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got result %h expected none queued", name, block_out);
        end else begin
            check(name, block_out, exp_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one block through accept, BUSY, an optional DONE stall, and release.
    task automatic run_block(input logic enc, input logic [127:0] blk,
                             input logic [127:0] exp, input int stall);
        int n;
        check("idle_in_ready", in_ready, 1'b1);
        in_valid = 1'b1; encrypt = enc; block_in = blk;
        tick();
        exp_q.push_back(exp);
        in_valid = 1'b0; encrypt = ~enc; block_in = {$urandom, $urandom, $urandom, $urandom};
        check("busy_mode", sbox_encrypt, enc);
        check("busy_byte0", sbox_byte_in, blk[127:120]);
        check("busy_in_ready", in_ready, 1'b0);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check("latency", n, 16);
        for (int s = 0; s < stall; s++) begin
            in_valid = s[0];
            tick();
            check("stall_hold", {block_out, out_valid, in_ready}, {exp, 1'b1, 1'b0});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        pop_check("result");
        tick();
        out_ready = 1'b0;
        check("release_state", {out_valid, in_ready}, 2'b01);
        check("retained_result", block_out, exp);
        check("idle_sbox", {sbox_encrypt, sbox_byte_in}, {enc, 8'h00});
    endtask

    initial begin
        int acc_n, got, seen;
        int acc_cyc [2];
        logic accepted;
        build_tables();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; encrypt = 1'b0; block_in = '0;
        vecs[0] = '{enc: 1'b1, blk: 128'h0, exp: {16{8'h63}}, stall: 0};
        vecs[1] = '{enc: 1'b0, blk: {16{8'h63}}, exp: 128'h0, stall: 0};
        vecs[2] = '{enc: 1'b1, blk: 128'h00112233445566778899aabbccddeeff,
                    exp: 128'h638293c31bfc33f5c4eeacea4bc12816, stall: 0};
        vecs[3] = '{enc: 1'b0, blk: 128'h638293c31bfc33f5c4eeacea4bc12816,
                    exp: 128'h00112233445566778899aabbccddeeff, stall: 10};
        repeat (2) tick();
        reset = 1'b0;
        check("reset_outputs", {in_ready, out_valid, sbox_encrypt, sbox_byte_in}, {3'b101, 8'h00});
        check("reset_block_out", block_out, 128'h0);

        for (int i = 0; i < 4; i++)
            run_block(vecs[i].enc, vecs[i].blk, vecs[i].exp, vecs[i].stall);

        // Reset while BUSY at byte index 7 must discard the block entirely.
        in_valid = 1'b1; encrypt = 1'b1; block_in = 128'h00112233445566778899aabbccddeeff;
        tick();
        exp_q.push_back(128'h638293c31bfc33f5c4eeacea4bc12816);
        in_valid = 1'b0;
        repeat (7) tick();
        check("busy_index7", sbox_byte_in, 8'h77);
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        exp_q.delete();
        check("midreset_state", {in_ready, out_valid, sbox_encrypt, sbox_byte_in}, {3'b101, 8'h00});
        check("midreset_block_out", block_out, 128'h0);
        seen = 0;
        repeat (20) begin
            if (out_valid) seen = 1;
            tick();
        end
        check("no_stale_out_valid", seen, 0);
        run_block(1'b1, {16{8'h53}}, {16{8'hed}}, 0);

        // Back-to-back with out_ready tied high.
        bb[0] = vecs[2];
        bb[1] = vecs[3];
        acc_n = 0; got = 0;
        acc_cyc[0] = 0; acc_cyc[1] = 0;
        out_ready = 1'b1; in_valid = 1'b1; encrypt = bb[0].enc; block_in = bb[0].blk;
        for (int c = 0; c < 80 && got < 2; c++) begin
            accepted = 1'b0;
            if (in_valid && in_ready && acc_n < 2) begin
                exp_q.push_back(bb[acc_n].exp);
                acc_cyc[acc_n] = c;
                acc_n++;
                accepted = 1'b1;
            end
            if (out_valid) begin
                pop_check("b2b_result");
                got++;
            end
            tick();
            if (accepted) begin
                if (acc_n < 2) begin
                    encrypt = bb[acc_n].enc; block_in = bb[acc_n].blk;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0; in_valid = 1'b0;
        check("b2b_accepts", acc_n, 2);
        check("b2b_results", got, 2);
        check("b2b_spacing", acc_cyc[1] - acc_cyc[0], 18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
